// File: rtl/os_mac_pe.sv
// Output-stationary systolic MAC cell: registered operand forwarding, two-stage
// multiply-accumulate with optional saturation, and a shadow drain register for tile unload.
module os_mac_pe #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 32,
    parameter int SATURATE  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     i_a_in,
    input  logic [WIDTH-1:0]     i_b_in,
    input  logic                 i_in_valid,
    input  logic                 i_acc_clear,
    input  logic                 i_signed_mode,
    output logic [WIDTH-1:0]     o_a_out,
    output logic [WIDTH-1:0]     o_b_out,
    output logic                 o_valid_out,
    output logic                 o_clear_out,
    output logic                 o_mode_out,
    input  logic                 i_drain_load,
    input  logic                 i_drain_shift,
    input  logic [ACC_WIDTH-1:0] i_drain_in,
    output logic [ACC_WIDTH-1:0] o_drain_out,
    output logic [ACC_WIDTH-1:0] o_result,
    output logic                 o_ovf
);

    localparam int EXT = ACC_WIDTH + 1 - 2 * WIDTH;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_valid;
    logic                 r_clear;
    logic                 r_mode;
    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_ovf;
    logic [ACC_WIDTH-1:0] r_drain;

    logic signed [2*WIDTH-1:0] w_prod_s;
    logic        [2*WIDTH-1:0] w_prod_u;
    logic        [ACC_WIDTH:0] w_prod_ext;
    logic        [ACC_WIDTH:0] w_sum;
    logic                      w_overflow;
    logic [ACC_WIDTH-1:0]      w_acc_next;
    logic                      w_ovf_next;

    // Stage 1: operands are forwarded unconditionally; clear is only meaningful on a valid beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_valid <= 1'b0;
            r_clear <= 1'b0;
            r_mode  <= 1'b0;
        end else begin
            r_a     <= i_a_in;
            r_b     <= i_b_in;
            r_valid <= i_in_valid;
            r_clear <= i_acc_clear & i_in_valid;
            r_mode  <= i_signed_mode;
        end
    end

    assign w_prod_s   = $signed(r_a) * $signed(r_b);
    assign w_prod_u   = r_a * r_b;
    assign w_prod_ext = r_mode ? {{EXT{w_prod_s[2*WIDTH-1]}}, w_prod_s}
                               : {{EXT{1'b0}}, w_prod_u};
    assign w_sum      = {r_acc[ACC_WIDTH-1], r_acc} + w_prod_ext;
    assign w_overflow = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];

    // A clear beat always fits, so only the accumulate path can overflow
    always_comb begin
        w_acc_next = r_acc;
        w_ovf_next = r_ovf;
        if (r_clear) begin
            w_acc_next = w_prod_ext[ACC_WIDTH-1:0];
            w_ovf_next = 1'b0;
        end else begin
            if (w_overflow && (SATURATE != 0)) begin
                w_acc_next = w_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
            end else begin
                w_acc_next = w_sum[ACC_WIDTH-1:0];
            end
            w_ovf_next = r_ovf | w_overflow;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (r_valid) begin
            r_acc <= w_acc_next;
            r_ovf <= w_ovf_next;
        end
    end

    // Load samples the pre-edge accumulator, so it can coincide with a new tile's clear beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drain <= '0;
        end else if (i_drain_load) begin
            r_drain <= r_acc;
        end else if (i_drain_shift) begin
            r_drain <= i_drain_in;
        end
    end

    assign o_a_out     = r_a;
    assign o_b_out     = r_b;
    assign o_valid_out = r_valid;
    assign o_clear_out = r_clear;
    assign o_mode_out  = r_mode;
    assign o_drain_out = r_drain;
    assign o_result    = r_acc;
    assign o_ovf       = r_ovf;

endmodule

// File: doc/os_mac_pe.md
# os_mac_pe

Parametrised processing element for the output-stationary systolic array: a two-stage multiply-accumulate cell with valid-qualified operands, per-beat signed/unsigned mode, tile clear, optional saturation and a shadow drain register. Operands are forwarded one hop east (A) and south (B) each cycle. Finished tiles shift out on a column drain chain while the next tile accumulates. Replaces the fixed 8-bit free-running MAC cell in every array position.

## Interface
- WIDTH, 8, operand width in bits.
- ACC_WIDTH, 32, accumulator width; must be >= 2*WIDTH+1.
- SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low; clock clk.
- a_in  in  WIDTH  A operand from west neighbour.
- b_in  in  WIDTH  B operand from north neighbour.
- in_valid  in  1  a_in/b_in/acc_clear/signed_mode qualify this beat.
- acc_clear  in  1  first beat of a tile: product replaces accumulator.
- signed_mode  in  1  1 = operands signed, 0 = unsigned.
- a_out  out  WIDTH  registered a_in to east neighbour.
- b_out  out  WIDTH  registered b_in to south neighbour.
- valid_out  out  1  registered in_valid.
- clear_out  out  1  registered acc_clear.
- mode_out  out  1  registered signed_mode.
- drain_load  in  1  copy accumulator into drain register.
- drain_shift  in  1  drain register takes drain_in.
- drain_in  in  ACC_WIDTH  drain value from north neighbour.
- drain_out  out  ACC_WIDTH  drain register.
- result  out  ACC_WIDTH  live accumulator.
- ovf  out  1  sticky overflow flag for current tile.

## Operation
- Stage 1 (S1): on every clk edge, register a_in, b_in, in_valid, acc_clear & in_valid, and signed_mode. These registers drive a_out, b_out, valid_out, clear_out and mode_out directly. Forwarding is unconditional; valid_out marks meaningful data.
- Stage 2 (S2): product = S1.a × S1.b, 2*WIDTH bits. Signed mode uses a signed multiply; unsigned mode zero-extends. The product is then extended to ACC_WIDTH+1 bits: sign-extended in signed mode, zero-extended in unsigned mode.
- Accumulate, only when S1.valid = 1:
  - S1.clear = 1: acc <= product (fits, no overflow); ovf <= 0.
  - S1.clear = 0: sum = acc (sign-extended) + product in ACC_WIDTH+1 bits. Overflow when sum[ACC_WIDTH] != sum[ACC_WIDTH-1].
  - On overflow with SATURATE=1, acc clamps to max positive (0x7FFF_FFFF at the default width) or max negative (0x8000_0000). With SATURATE=0, acc takes the low ACC_WIDTH bits.
  - ovf <= ovf | overflow.
- When S1.valid = 0, acc and ovf hold.
- Unsigned mode still stores acc as a signed ACC_WIDTH value; the ACC_WIDTH >= 2*WIDTH+1 rule guarantees any single product fits.
- Drain register:
  - drain_load = 1: drain_reg <= acc, taking the acc value before this edge's update.
  - Else drain_shift = 1: drain_reg <= drain_in.
  - Else drain_reg holds.
  - Simultaneous load and shift: load wins.
- Drain activity is independent of accumulation; both may occur on the same edge.

## Timing
- Reset: every register, including the S1 operand registers, is cleared to 0. This covers a_out, b_out, valid_out, clear_out, mode_out, result, ovf and drain_out.
- Forward latency: 1 cycle. Inputs sampled at edge k appear on a_out/b_out/valid_out after edge k.
- Accumulate latency: 2 edges. A beat sampled at edge k is reflected in result after edge k+1.
- Throughput: one beat per cycle. Back-to-back valid beats accumulate with no bubbles.
- A clear beat at edge k+1 with drain_load on the same edge: drain_reg captures the old tile's total and acc starts the new tile. This is the required tile-boundary idiom.
- Reset mid-tile: acc, ovf, the pipeline and drain are all cleared immediately (asynchronous). No partial result survives.
- Clear on a beat with in_valid = 0 is ignored: gated into S1.clear.

## Test plan
- Reset then signed beats (clear, 3, -4), (5, 6), (-128, -128): result 0 → -12 → 18 → 16402; a_out/b_out track the inputs one cycle later.
- Unsigned beat (clear, 255, 255), then (255, 255): result 65025 → 130050; the same bit patterns in signed mode give 1 → 2.
- SATURATE=1, ACC_WIDTH=17: signed (-128, -128) repeated 5 times → result clamps at 65535 and ovf=1; a next clear beat clears ovf. With SATURATE=0, the same stimulus wraps.
- Gap beats: valid pattern 1, 0, 0, 1 with (2, 2) each → result 4 then 8; result holds during the gaps; valid_out mirrors the pattern delayed 1 cycle.
- Tile boundary: acc = 100, drain_load together with a clear beat (7, 1) → drain_out = 100, result = 7. Then drain_shift with drain_in = 55 → drain_out = 55. Load and shift asserted together → load wins.
- Assert rst_n low mid-tile with acc = 500 and a valid beat in S1 → all outputs read 0 immediately; the first post-reset non-clear beat (2, 3) gives result 6.
